// File: rtl/wb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : wb_mem_responder
// Purpose  : Classic Wishbone slave backed by a byte-enabled word memory,
//            answering after a fixed latency, with read/write transfer counters.
// Revision : 1.0
// ============================================================================

module wb_mem_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'h3800_0000,
    parameter int          DEPTH_LOG2 = 10,
    parameter int          LATENCY    = 3
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [15:0] rd_count_o,
    output logic [15:0] wr_count_o
);

    localparam int          c_NUM_WORDS    = 1 << DEPTH_LOG2;
    localparam logic [32:0] c_WINDOW_BYTES = 33'(c_NUM_WORDS) << 2;
    localparam logic [3:0]  c_LAT_LOAD     = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t                  r_state_q, w_state_d;
    logic [3:0]              r_cnt_q, w_cnt_d;
    logic                    r_we_q, w_we_d;
    logic [3:0]              r_sel_q, w_sel_d;
    logic [31:0]             r_dat_q, w_dat_d;
    logic [DEPTH_LOG2-1:0]   r_idx_q, w_idx_d;
    logic [15:0]             r_rd_cnt_q, w_rd_cnt_d;
    logic [15:0]             r_wr_cnt_q, w_wr_cnt_d;

    logic [31:0]             r_mem [0:c_NUM_WORDS-1];

    logic [31:0]             w_offset;
    logic                    w_in_window;
    logic                    w_req;
    logic                    w_mem_we;

    // Offset compare avoids overflow of BASE_ADDR + window near the top of the map.
    assign w_offset    = wbs_adr_i - BASE_ADDR;
    assign w_in_window = (wbs_adr_i >= BASE_ADDR) && ({1'b0, w_offset} < c_WINDOW_BYTES);
    assign w_req       = wbs_stb_i & wbs_cyc_i;

    always_comb begin
        w_state_d  = r_state_q;
        w_cnt_d    = r_cnt_q;
        w_we_d     = r_we_q;
        w_sel_d    = r_sel_q;
        w_dat_d    = r_dat_q;
        w_idx_d    = r_idx_q;
        w_rd_cnt_d = r_rd_cnt_q;
        w_wr_cnt_d = r_wr_cnt_q;

        case (r_state_q)
            S_IDLE: begin
                if (w_req && w_in_window) begin
                    w_we_d  = wbs_we_i;
                    w_sel_d = wbs_sel_i;
                    w_dat_d = wbs_dat_i;
                    w_idx_d = w_offset[DEPTH_LOG2+1:2];
                    w_cnt_d = c_LAT_LOAD;
                    w_state_d = (c_LAT_LOAD == 4'd0) ? S_ACK : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!w_req) begin
                    w_state_d = S_IDLE;
                end else begin
                    w_cnt_d = r_cnt_q - 4'd1;
                    if (r_cnt_q <= 4'd1) begin
                        w_state_d = S_ACK;
                    end
                end
            end
            S_ACK: begin
                w_state_d = S_IDLE;
                if (r_we_q) begin
                    w_wr_cnt_d = r_wr_cnt_q + 16'd1;
                end else begin
                    w_rd_cnt_d = r_rd_cnt_q + 16'd1;
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state_q  <= S_IDLE;
            r_cnt_q    <= 4'd0;
            r_we_q     <= 1'b0;
            r_sel_q    <= 4'd0;
            r_dat_q    <= 32'd0;
            r_idx_q    <= '0;
            r_rd_cnt_q <= 16'd0;
            r_wr_cnt_q <= 16'd0;
        end else begin
            r_state_q  <= w_state_d;
            r_cnt_q    <= w_cnt_d;
            r_we_q     <= w_we_d;
            r_sel_q    <= w_sel_d;
            r_dat_q    <= w_dat_d;
            r_idx_q    <= w_idx_d;
            r_rd_cnt_q <= w_rd_cnt_d;
            r_wr_cnt_q <= w_wr_cnt_d;
        end
    end

    // Memory is deliberately outside reset; a reset on the ACK edge drops the write.
    assign w_mem_we = (r_state_q == S_ACK) && r_we_q && !wb_rst_i;

    always_ff @(posedge wb_clk_i) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (r_sel_q[b]) begin
                    r_mem[r_idx_q][8*b +: 8] <= r_dat_q[8*b +: 8];
                end
            end
        end
    end

    assign wbs_ack_o  = (r_state_q == S_ACK);
    assign wbs_dat_o  = ((r_state_q == S_ACK) && !r_we_q) ? r_mem[r_idx_q] : 32'd0;
    assign rd_count_o = r_rd_cnt_q;
    assign wr_count_o = r_wr_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_mem_responder
// Purpose  : Directed, table-driven self-checking bench for wb_mem_responder.
// Revision : 1.0
// ============================================================================

module tb_wb_mem_responder;

    logic        clk;
    logic        rst;
    logic        stb;
    logic        cyc;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat_w;
    logic [31:0] adr;
    logic        ack;
    logic [31:0] dat_r;
    logic [15:0] rd_cnt;
    logic [15:0] wr_cnt;

    int checks = 0;
    int errors = 0;
    int exp_rd = 0;
    int exp_wr = 0;

    localparam int c_ACK_CYCLE = 3;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        bit          ack;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [13];

    wb_mem_responder #(
        .BASE_ADDR  (32'h3800_0000),
        .DEPTH_LOG2 (10),
        .LATENCY    (3)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wbs_stb_i  (stb),
        .wbs_cyc_i  (cyc),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_dat_i  (dat_w),
        .wbs_adr_i  (adr),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (dat_r),
        .rd_count_o (rd_cnt),
        .wr_count_o (wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        stb = 1'b0;
        cyc = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        exp_rd = 0;
        exp_wr = 0;
    endtask

    // One classic transfer: request held until ack (or 20 cycles), then dropped.
    task automatic xfer(input logic t_we, input logic [31:0] t_adr, input logic [3:0] t_sel,
                        input logic [31:0] t_dat, input bit t_ack, input logic [31:0] t_exp,
                        input string name);
        int          ack_cyc;
        logic [31:0] rdata;
        ack_cyc = -1;
        rdata   = 32'd0;
        @(posedge clk); #1;
        stb = 1'b1; cyc = 1'b1; we = t_we; sel = t_sel; dat_w = t_dat; adr = t_adr;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ack) begin
                ack_cyc = c;
                rdata   = dat_r;
                break;
            end
        end
        @(posedge clk); #1;
        stb = 1'b0; cyc = 1'b0;
        chk({name, " ack_cycle"}, 32'(ack_cyc), t_ack ? 32'(c_ACK_CYCLE) : 32'hFFFF_FFFF);
        if (t_ack && !t_we) begin
            chk({name, " rdata"}, rdata, t_exp);
        end
        if (t_ack) begin
            if (t_we) exp_wr++;
            else      exp_rd++;
        end
        @(negedge clk);
        chk({name, " rd_count"}, {16'd0, rd_cnt}, 32'(exp_rd));
        chk({name, " wr_count"}, {16'd0, wr_cnt}, 32'(exp_wr));
    endtask

    function automatic logic [31:0] burst_word(input int i);
        return 32'hA000_0000 + 32'(i) * 32'h0000_0101;
    endfunction

    initial begin
        int acks;
        int n;
        int last;
        int cyc_no;

        rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0;
        sel = 4'h0; dat_w = 32'd0; adr = 32'd0;

        vecs[0]  = '{1'b1, 32'h3800_0010, 4'hF, 32'hDEAD_BEEF, 1'b1, 32'h0};
        vecs[1]  = '{1'b0, 32'h3800_0010, 4'hF, 32'h0,         1'b1, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 32'h3800_0020, 4'hF, 32'h1122_3344, 1'b1, 32'h0};
        vecs[3]  = '{1'b1, 32'h3800_0020, 4'h2, 32'h0000_AB00, 1'b1, 32'h0};
        vecs[4]  = '{1'b0, 32'h3800_0020, 4'h0, 32'h0,         1'b1, 32'h1122_AB44};
        vecs[5]  = '{1'b1, 32'h3000_0084, 4'hF, 32'h5555_5555, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 32'h3800_1000, 4'hF, 32'h0,         1'b0, 32'h0};
        vecs[7]  = '{1'b0, 32'h37FF_FFFC, 4'hF, 32'h0,         1'b0, 32'h0};
        vecs[8]  = '{1'b1, 32'h3800_0FFC, 4'hF, 32'hCAFE_F00D, 1'b1, 32'h0};
        vecs[9]  = '{1'b0, 32'h3800_0FFE, 4'hF, 32'h0,         1'b1, 32'hCAFE_F00D};
        vecs[10] = '{1'b1, 32'h3800_0004, 4'hF, 32'h0000_0000, 1'b1, 32'h0};
        vecs[11] = '{1'b1, 32'h3800_0004, 4'h9, 32'hFFFF_FFFF, 1'b1, 32'h0};
        vecs[12] = '{1'b0, 32'h3800_0004, 4'hF, 32'h0,         1'b1, 32'hFF00_00FF};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset ack", {31'd0, ack}, 32'd0);
        chk("reset dat", dat_r, 32'd0);
        chk("reset rd_count", {16'd0, rd_cnt}, 32'd0);
        chk("reset wr_count", {16'd0, wr_cnt}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            xfer(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat, vecs[i].ack, vecs[i].exp,
                 $sformatf("vec%0d", i));
        end

        // Abort: cyc dropped in cycle 1 of a write
        acks = 0;
        @(posedge clk); #1;
        stb = 1'b1; cyc = 1'b1; we = 1'b1; sel = 4'hF; dat_w = 32'h1234_5678; adr = 32'h3800_0010;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ack) acks++;
            @(posedge clk); #1;
            if (c == 0) cyc = 1'b0;
            if (c == 1) stb = 1'b0;
        end
        chk("abort acks", 32'(acks), 32'd0);
        xfer(1'b0, 32'h3800_0010, 4'hF, 32'h0, 1'b1, 32'hDEAD_BEEF, "abort readback");

        // Reset pulsed in cycle 2 of a read
        acks = 0;
        @(posedge clk); #1;
        stb = 1'b1; cyc = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h3800_0020;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ack) acks++;
            @(posedge clk); #1;
            if (c == 1) rst = 1'b1;
            if (c == 2) begin
                rst = 1'b0; stb = 1'b0; cyc = 1'b0;
            end
        end
        exp_rd = 0;
        exp_wr = 0;
        chk("midreset acks", 32'(acks), 32'd0);
        chk("midreset rd_count", {16'd0, rd_cnt}, 32'd0);
        chk("midreset wr_count", {16'd0, wr_cnt}, 32'd0);
        xfer(1'b0, 32'h3800_0010, 4'hF, 32'h0, 1'b1, 32'hDEAD_BEEF, "retain 0010");
        xfer(1'b0, 32'h3800_0020, 4'hF, 32'h0, 1'b1, 32'h1122_AB44, "retain 0020");

        // DMA-style burst of 16 reads
        for (int i = 0; i < 16; i++) begin
            xfer(1'b1, 32'h3800_0100 + 32'(4 * i), 4'hF, burst_word(i), 1'b1, 32'h0,
                 $sformatf("preload%0d", i));
        end
        do_reset();
        n = 0;
        last = -1;
        cyc_no = 0;
        @(posedge clk); #1;
        stb = 1'b1; cyc = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h3800_0100;
        while (n < 16 && cyc_no < 200) begin
            @(negedge clk);
            if (ack) begin
                chk($sformatf("burst%0d data", n), dat_r, burst_word(n));
                if (n > 0) chk($sformatf("burst%0d spacing", n), 32'(cyc_no - last), 32'd4);
                last = cyc_no;
                n++;
            end
            @(posedge clk); #1;
            if (last == cyc_no) begin
                if (n < 16) adr = 32'h3800_0100 + 32'(4 * n);
                else begin
                    stb = 1'b0; cyc = 1'b0;
                end
            end
            cyc_no++;
        end
        stb = 1'b0; cyc = 1'b0;
        chk("burst ack total", 32'(n), 32'd16);
        @(negedge clk);
        chk("burst rd_count", {16'd0, rd_cnt}, 32'd16);
        chk("burst wr_count", {16'd0, wr_cnt}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
